// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - receive-port state type and header field constants
package router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY,
    DONE
  } rx_state_t;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int ADDR_W      = 2;
  localparam int LEN_W       = 6;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/router_rx_parity.sv
// rtl/router_rx_parity.sv - running XOR accumulator with clear, accumulate-enable and compare
module router_rx_parity (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       acc_en,
  input  logic [7:0] din,
  output logic       mismatch
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  // clr and acc_en together load din, which is how the header seeds the sum
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 8'h00;
    end
    if (acc_en) begin
      acc_d = acc_d ^ din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign mismatch = (acc_q != din);

endmodule

// File: rtl/router_rx_port.sv
// rtl/router_rx_port.sv - drains one router output FIFO and frames payload bytes
// Parity checking is built only when ROUTER_RX_PARITY_CHK_EN is defined.
module router_rx_port
  import router_pkg::*;
#(
  parameter int PORT_ID = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vld_out,
  input  logic [7:0]       data_out,
  input  logic             stall,
  output logic             read_enb,
  output logic [7:0]       pkt_byte,
  output logic             pkt_byte_valid,
  output logic             pkt_sop,
  output logic             pkt_eop,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             addr_err,
  output logic             pkt_abort,
  output logic [CNT_W-1:0] pkt_count
);

  localparam logic [LEN_W:0] LEFT_ONE = (LEN_W + 1)'(1);
  localparam logic [LEN_W:0] LEFT_TWO = (LEN_W + 1)'(2);

  rx_state_t        state_q, state_d;
  logic [LEN_W:0]   req_left_q, req_left_d;
  logic [LEN_W:0]   cap_left_q, cap_left_d;
  logic             rd_pend_q, rd_pend_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             addr_err_q, addr_err_d;
  logic             par_err_q, par_err_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_vld_q, byte_vld_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             par_mismatch;

`ifdef ROUTER_RX_PARITY_CHK_EN
  logic par_clr;
  logic par_acc;

  assign par_clr = (state_q == HDR);
  assign par_acc = (state_q == HDR) ||
                   ((state_q == BODY) && rd_pend_q && (cap_left_q != LEFT_ONE));

  router_rx_parity u_parity (
    .clock    (clock),
    .reset    (reset),
    .clr      (par_clr),
    .acc_en   (par_acc),
    .din      (data_out),
    .mismatch (par_mismatch)
  );
`else
  assign par_mismatch = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_left_d = req_left_q;
    cap_left_d = cap_left_q;
    rd_pend_d  = 1'b0;
    len_d      = len_q;
    addr_err_d = addr_err_q;
    par_err_d  = par_err_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    count_d    = count_q;
    read_enb   = 1'b0;

    case (state_q)
      IDLE: begin
        if (vld_out && !stall) begin
          read_enb = 1'b1;
          state_d  = HDR;
        end
      end
      HDR: begin
        len_d      = data_out[HDR_LEN_MSB:HDR_LEN_LSB];
        addr_err_d = (data_out[ADDR_W-1:0] != PORT_ID[ADDR_W-1:0]);
        req_left_d = {1'b0, data_out[HDR_LEN_MSB:HDR_LEN_LSB]} + LEFT_ONE;
        cap_left_d = {1'b0, data_out[HDR_LEN_MSB:HDR_LEN_LSB]} + LEFT_ONE;
        state_d    = BODY;
      end
      BODY: begin
        read_enb = vld_out && !stall && (req_left_q != '0);
        if (read_enb) begin
          req_left_d = req_left_q - LEFT_ONE;
          rd_pend_d  = 1'b1;
        end
        if (rd_pend_q) begin
          cap_left_d = cap_left_q - LEFT_ONE;
          if (cap_left_q == LEFT_ONE) begin
            par_err_d = par_mismatch;
            done_d    = 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
              count_d = count_q + CNT_W'(1);
            end
            state_d = DONE;
          end else begin
            byte_d     = data_out;
            byte_vld_d = 1'b1;
            sop_d      = (cap_left_q == ({1'b0, len_q} + LEFT_ONE));
            eop_d      = (cap_left_q == LEFT_TWO);
          end
        end else if (!vld_out && (req_left_q != '0)) begin
          // FIFO emptied under us with nothing in flight: the router flushed the port
          abort_d = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_left_q <= '0;
      cap_left_q <= '0;
      rd_pend_q  <= 1'b0;
      len_q      <= '0;
      addr_err_q <= 1'b0;
      par_err_q  <= 1'b0;
      byte_q     <= 8'h00;
      byte_vld_q <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_left_q <= req_left_d;
      cap_left_q <= cap_left_d;
      rd_pend_q  <= rd_pend_d;
      len_q      <= len_d;
      addr_err_q <= addr_err_d;
      par_err_q  <= par_err_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      count_q    <= count_d;
    end
  end

  assign pkt_byte       = byte_q;
  assign pkt_byte_valid = byte_vld_q;
  assign pkt_sop        = sop_q;
  assign pkt_eop        = eop_q;
  assign pkt_len        = len_q;
  assign pkt_done       = done_q;
  assign parity_err     = par_err_q;
  assign addr_err       = addr_err_q;
  assign pkt_abort      = abort_q;
  assign pkt_count      = count_q;

endmodule
